// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch system-ID boot checker.
package stopwatch_pkg;

  // Sequencer states for the boot-time system-ID check.
  typedef enum logic [2:0] {
    SETTLE,
    RD_ID,
    RD_TS,
    GAP,
    CHECK,
    RETRY,
    DONE,
    FAIL
  } state_t;

  // Word select values on the system-ID slave.
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // True in the two states that hold a read strobe on the bus.
  function automatic logic is_read_state(input state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/stopwatch_avm_read_timer.sv
// Stall counter for one Avalon read: counts consecutive waitrequest cycles
// and flags the cycle in which the stall budget runs out.
module stopwatch_avm_read_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic tc
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] count;

  // Count stall cycles; saturate instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // Terminal count: this stall cycle is the LIMIT-th in a row.
  assign tc = count_en && (count == LAST);

endmodule

// File: rtl/stopwatch_sysid_checker.sv
// Boot-time sequencer: reads the system-ID and timestamp words, compares them
// against build-time values, retries on mismatch or timeout, and reports status.
module stopwatch_sysid_checker
  import stopwatch_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1571601221,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        restart,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRIES);

  state_t     state;
  logic [7:0] settle_cnt;
  logic       accept;
  logic       in_read;
  logic       stall_tc;
  logic       words_match;

  assign accept      = avm_read && !avm_waitrequest;
  assign in_read     = is_read_state(state);
  assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);

  // Stall timer runs only while a strobe is pending; any exit or restart clears it.
  stopwatch_avm_read_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!in_read || restart),
    .count_en (in_read && avm_read && avm_waitrequest),
    .tc       (stall_tc)
  );

  // Sequencer with all bus and status outputs registered.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking = would make later lines read already-updated state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SETTLE;
      settle_cnt  <= '0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_count <= '0;
    end else if (restart) begin
      // Restart beats any accept or timeout in the same cycle.
      state       <= SETTLE;
      settle_cnt  <= '0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      retry_count <= '0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        RD_ID: begin
          // Accept beats timeout in the same cycle.
          if (accept) begin
            id_value <= avm_readdata;
            avm_read <= 1'b0;
            state    <= GAP;
          end else if (stall_tc) begin
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RETRY;
          end
        end
        GAP: begin
          state       <= RD_TS;
          avm_read    <= 1'b1;
          avm_address <= SYSID_ADDR_TS;
        end
        RD_TS: begin
          if (accept) begin
            ts_value <= avm_readdata;
            avm_read <= 1'b0;
            state    <= CHECK;
          end else if (stall_tc) begin
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RETRY;
          end
        end
        CHECK: begin
          // A completed read pair is not a timeout, whatever the comparison says.
          timeout_err <= 1'b0;
          if (words_match) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= RETRY;
          end
        end
        RETRY: begin
          if (retry_count < RETRY_MAX) begin
            retry_count <= retry_count + 4'd1;
            settle_cnt  <= '0;
            avm_address <= SYSID_ADDR_ID;
            state       <= SETTLE;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FAIL;
          end
        end
        DONE, FAIL: begin
          state <= state;
        end
        default: begin
          state <= SETTLE;
        end
      endcase
    end
  end

endmodule
